flex_counter_ext: RTL
=====================

FLEX_COUNTER_EXT -- requirements
Module: flex_counter_ext

Interface
REQ-001 Parameter NUM_BITS, default 10, width of count path.
REQ-002 Parameter PRESCALE_BITS, default 4, width of prescaler.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 clear  input  1  synchronous clear of count and prescaler.
REQ-006 count_enable  input  1  qualifies prescaler advance.
REQ-007 load  input  1  synchronous load of load_val.
REQ-008 load_val  input  NUM_BITS  value loaded on load.
REQ-009 up_down  input  1  1 = count up, 0 = count down.
REQ-010 saturate  input  1  1 = hold at terminal value, 0 = wrap.
REQ-011 rollover_val  input  NUM_BITS  upper terminal value.
REQ-012 prescale_val  input  PRESCALE_BITS  step every prescale_val+1 enabled cycles.
REQ-013 count_out  output  NUM_BITS  registered count.
REQ-014 rollover_flag  output  1  count_out at terminal value for current direction.
REQ-015 wrap_pulse  output  1  registered one-cycle pulse marking a wrap.

Function
REQ-016 Priority per edge: rst > clear > load > step; at most one applies.
REQ-017 clear: count_out <= 0, prescaler <= 0, wrap_pulse <= 0.
REQ-018 load: count_out <= load_val, prescaler <= 0, wrap_pulse <= 0; no step that cycle.
REQ-019 Prescaler: with count_enable=1, if prescaler == prescale_val a step occurs and prescaler <= 0, else prescaler increments; count_enable=0 holds prescaler, no step.
REQ-020 prescale_val = 0: step on every enabled cycle (latency 1 edge, identical to legacy counter).
REQ-021 Prescaler > prescale_val (prescale_val lowered mid-run): treated as match; step occurs, prescaler <= 0.
REQ-022 Up step, count_out < rollover_val: count_out + 1.
REQ-023 Up step, count_out >= rollover_val: wrap mode -> 0 and wrap_pulse <= 1; saturate mode -> hold, wrap_pulse <= 0.
REQ-024 Down step, count_out > 0: count_out - 1 (also when above rollover_val after load).
REQ-025 Down step, count_out == 0: wrap mode -> rollover_val and wrap_pulse <= 1; saturate mode -> hold 0, wrap_pulse <= 0.
REQ-026 wrap_pulse <= 0 on every edge not performing a wrap; never high two consecutive cycles unless a wrap occurs on each.
REQ-027 rollover_val = 0, up, wrap mode: count stays 0, wrap_pulse each step.
REQ-028 rollover_flag combinational from registered state: up_down=1 -> (count_out == rollover_val); up_down=0 -> (count_out == 0).
REQ-029 up_down, saturate, rollover_val sampled at each step edge; changes take effect on the next step, no glitch on count_out.
REQ-030 No arithmetic overflow: all compares and increments at NUM_BITS width, no carry out.

Reset
REQ-031 rst=1 at edge: count_out <= 0, prescaler <= 0, wrap_pulse <= 0, regardless of other inputs.
REQ-032 rst asserted mid-count or mid-prescale aborts operation; counting resumes from 0 on first enabled cycle after rst deasserts.
REQ-033 During reset rollover_flag reflects count_out=0 per REQ-028.

Verification
REQ-034 Up/wrap, prescale_val=0, rollover_val=5, enable 7 cycles -> count 1,2,3,4,5,0,1; wrap_pulse high only cycle after 5->0; rollover_flag high while count=5.
REQ-035 Down/saturate, load_val=3, then enable 5 cycles -> 3,2,1,0,0,0; wrap_pulse never high; rollover_flag high at 0.
REQ-036 Prescale: prescale_val=2, up, enable continuous 9 cycles -> count increments only on cycles 3,6,9 (values 1,2,3); toggle count_enable low mid-period -> prescaler holds.
REQ-037 Priority: clear, load, count_enable all high with count=4 -> count 0; load and enable high -> count = load_val, prescaler 0.
REQ-038 Up/wrap, rollover_val=5, load_val=9, one step -> count 0, wrap_pulse 1; rollover_val=0 -> count remains 0, wrap_pulse each step.
REQ-039 rst asserted at count=3, prescaler=1 for one cycle -> count 0, wrap_pulse 0; next enabled step (prescale_val=0) gives count 1.

Source files
------------

// File: rtl/flex_counter_ext.sv
// flex_counter_ext: up/down counter with a programmable rollover value.
// The count can wrap or saturate at its end values, and an enable prescaler
// controls how often it steps. A registered pulse marks each wrap.
module flex_counter_ext #(
    parameter int NUM_BITS      = 10,
    parameter int PRESCALE_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     count_enable,
    input  logic                     load,
    input  logic [NUM_BITS-1:0]      load_val,
    input  logic                     up_down,
    input  logic                     saturate,
    input  logic [NUM_BITS-1:0]      rollover_val,
    input  logic [PRESCALE_BITS-1:0] prescale_val,
    output logic [NUM_BITS-1:0]      count_out,
    output logic                     rollover_flag,
    output logic                     wrap_pulse
);

    localparam logic [NUM_BITS-1:0]      CNT_ONE = NUM_BITS'(1);
    localparam logic [PRESCALE_BITS-1:0] PRE_ONE = PRESCALE_BITS'(1);

    logic [PRESCALE_BITS-1:0] prescaler;
    logic                     step;
    logic [NUM_BITS-1:0]      next_count;
    logic                     next_wrap;

    // An enabled cycle steps the count when the prescaler has reached the
    // programmed period. It also steps when the prescaler has passed that
    // period, which happens if prescale_val was lowered while counting.
    assign step = count_enable && (prescaler >= prescale_val);

    // The terminal value depends on direction: rollover_val when counting up, 0 when counting down.
    assign rollover_flag = up_down ? (count_out == rollover_val) : (count_out == '0);

    // Value the count takes on a step, and whether that step wraps.
    // All arithmetic stays at NUM_BITS width. The comparisons keep +1 and -1 from carrying out.
    always_comb begin
        next_count = count_out;
        next_wrap  = 1'b0;
        if (up_down) begin
            if (count_out < rollover_val) begin
                next_count = count_out + CNT_ONE;
            end else if (!saturate) begin
                next_count = '0;
                next_wrap  = 1'b1;
            end
        end else begin
            if (count_out != '0) begin
                next_count = count_out - CNT_ONE;
            end else if (!saturate) begin
                next_count = rollover_val;
                next_wrap  = 1'b1;
            end
        end
    end

    // State update in priority order: reset, clear, load, then prescaled step.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_out  <= '0;
            prescaler  <= '0;
            wrap_pulse <= 1'b0;
        end else if (clear) begin
            count_out  <= '0;
            prescaler  <= '0;
            wrap_pulse <= 1'b0;
        end else if (load) begin
            count_out  <= load_val;
            prescaler  <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            if (step) begin
                prescaler  <= '0;
                count_out  <= next_count;
                wrap_pulse <= next_wrap;
            end else if (count_enable) begin
                prescaler <= prescaler + PRE_ONE;
            end
        end
    end

endmodule
